// File: rtl/trans_load_ctrl.sv
// rtl/trans_load_ctrl.sv - AXI4 read sequencer feeding one MMA operand set (A, B, optional C) into TRANS
package params;
    typedef enum logic [1:0] {TYPE_INT8 = 2'd0, TYPE_INT4 = 2'd1, TYPE_FP16 = 2'd2, TYPE_FP32 = 2'd3} type_t;
    typedef logic [1:0] rc_t;
    typedef enum logic [1:0] {MAT_A = 2'd0, MAT_B = 2'd1, MAT_C = 2'd2} mat_t;
endpackage

module trans_load_ctrl
    import params::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  type_t             cfg_type,
    input  rc_t               cfg_rc,
    input  logic              load_c,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [ADDR_W-1:0] addr_c,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic              arvalid,
    input  logic              arready,
    input  logic [255:0]      rdata,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,
    output logic [255:0]      trans_data,
    output logic [4:0]        trans_burst,
    output mat_t              trans_mat,
    output type_t             trans_type,
    output rc_t               trans_rc,
    output logic              trans_valid,
    output logic              busy,
    output logic              done,
    output logic              err
);
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_DRAIN, S_ERROR} state_t;

    state_t            r_state;
    mat_t              r_cur_mat;
    logic [4:0]        r_beat_cnt;
    type_t             r_type;
    rc_t               r_rc;
    logic              r_load_c;
    logic [ADDR_W-1:0] r_addr_a;
    logic [ADDR_W-1:0] r_addr_b;
    logic [ADDR_W-1:0] r_addr_c;

    logic [4:0]        w_last_idx;
    logic              w_last_exp;
    logic              w_beat;

    // Burst length and base follow the matrix currently being fetched.
    always_comb begin
        w_last_idx = 5'd31;
        araddr     = r_addr_c;
        case (r_cur_mat)
            MAT_A: begin
                w_last_idx = (r_type == TYPE_FP32) ? 5'd15 : 5'd7;
                araddr     = r_addr_a;
            end
            MAT_B: begin
                w_last_idx = (r_type == TYPE_INT4) ? 5'd15 : 5'd7;
                araddr     = r_addr_b;
            end
            default: ;
        endcase
    end

    assign arlen      = {3'b000, w_last_idx};
    assign arsize     = 3'b101;
    assign arburst    = 2'b01;
    assign w_last_exp = (r_beat_cnt == w_last_idx);
    assign w_beat     = (r_state == S_DATA) && rvalid && rready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cur_mat   <= MAT_A;
            r_beat_cnt  <= 5'd0;
            r_type      <= TYPE_INT8;
            r_rc        <= 2'b00;
            r_load_c    <= 1'b0;
            r_addr_a    <= '0;
            r_addr_b    <= '0;
            r_addr_c    <= '0;
            arvalid     <= 1'b0;
            rready      <= 1'b0;
            trans_data  <= '0;
            trans_burst <= 5'd0;
            trans_mat   <= MAT_A;
            trans_type  <= TYPE_INT8;
            trans_rc    <= 2'b00;
            trans_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            trans_valid <= 1'b0;
            done        <= 1'b0;
            // A beat is forwarded even when its rlast is wrong.
            if (w_beat) begin
                trans_data  <= rdata;
                trans_burst <= r_beat_cnt;
                trans_mat   <= r_cur_mat;
                trans_type  <= r_type;
                trans_rc    <= r_rc;
                trans_valid <= 1'b1;
                r_beat_cnt  <= r_beat_cnt + 5'd1;
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_type    <= cfg_type;
                        r_rc      <= cfg_rc;
                        r_load_c  <= load_c;
                        r_addr_a  <= addr_a;
                        r_addr_b  <= addr_b;
                        r_addr_c  <= addr_c;
                        r_cur_mat <= MAT_A;
                        busy      <= 1'b1;
                        if (cfg_rc == 2'b11) begin
                            r_state <= S_ERROR;
                            err     <= 1'b1;
                            done    <= 1'b1;
                        end else begin
                            r_state <= S_ADDR;
                            err     <= 1'b0;
                            arvalid <= 1'b1;
                        end
                    end
                end
                S_ADDR: begin
                    if (arready) begin
                        arvalid    <= 1'b0;
                        rready     <= 1'b1;
                        r_beat_cnt <= 5'd0;
                        r_state    <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_beat) begin
                        if (rlast != w_last_exp) begin
                            rready  <= 1'b0;
                            err     <= 1'b1;
                            done    <= 1'b1;
                            r_state <= S_ERROR;
                        end else if (w_last_exp) begin
                            rready <= 1'b0;
                            case (r_cur_mat)
                                MAT_A: begin
                                    r_cur_mat <= MAT_B;
                                    arvalid   <= 1'b1;
                                    r_state   <= S_ADDR;
                                end
                                MAT_B: begin
                                    if (r_load_c) begin
                                        r_cur_mat <= MAT_C;
                                        arvalid   <= 1'b1;
                                        r_state   <= S_ADDR;
                                    end else begin
                                        r_state <= S_DRAIN;
                                    end
                                end
                                default: r_state <= S_DRAIN;
                            endcase
                        end
                    end
                end
                // One cycle lets the final write leave the TRANS output register.
                S_DRAIN: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                S_ERROR: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_trans_load_ctrl.sv
// tb/tb_trans_load_ctrl.sv - directed self-checking bench for trans_load_ctrl
module tb_trans_load_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    params::type_t cfg_type;
    params::rc_t   cfg_rc;
    logic          load_c;
    logic [31:0]   addr_a, addr_b, addr_c, araddr;
    logic [7:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic          arvalid, arready, rlast, rvalid, rready;
    logic [255:0]  rdata, trans_data;
    logic [4:0]    trans_burst;
    params::mat_t  trans_mat;
    params::type_t trans_type;
    params::rc_t   trans_rc;
    logic          trans_valid, busy, done, err;

    int n_checks = 0;
    int n_fail = 0;
    int cyc_cnt = 0;

    logic [31:0]  ar_addr_log[$];
    int           ar_len_log[$];
    logic [266:0] tv_q[$];
    int           last_beat_cyc, done_cyc;
    logic         done_err;
    bit           done_seen;

    trans_load_ctrl #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_type(cfg_type), .cfg_rc(cfg_rc),
        .load_c(load_c), .addr_a(addr_a), .addr_b(addr_b), .addr_c(addr_c),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready), .rdata(rdata), .rlast(rlast),
        .rvalid(rvalid), .rready(rready), .trans_data(trans_data),
        .trans_burst(trans_burst), .trans_mat(trans_mat), .trans_type(trans_type),
        .trans_rc(trans_rc), .trans_valid(trans_valid), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;
    always @(negedge clk) if (trans_valid) tv_q.push_back({trans_mat, trans_type, trans_rc, trans_burst, trans_data});

    task automatic check(input string tag, input logic [271:0] got, input logic [271:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] pat(input int m, input int b);
        return {8{8'(m), 8'hA5, 8'(b), 8'h3C}};
    endfunction

    task automatic clear_logs();
        ar_addr_log.delete();
        ar_len_log.delete();
        tv_q.delete();
        done_seen = 0;
        done_err = 1'b0;
        done_cyc = 0;
        last_beat_cyc = 0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_arvalid"}, 272'(arvalid), 272'(0));
        check({tag, "_rready"}, 272'(rready), 272'(0));
        check({tag, "_tvalid"}, 272'(trans_valid), 272'(0));
        check({tag, "_tdata"}, 272'(trans_data), 272'(0));
        check({tag, "_tburst"}, 272'(trans_burst), 272'(0));
        check({tag, "_tmat"}, 272'(trans_mat), 272'(0));
        check({tag, "_busy"}, 272'(busy), 272'(0));
        check({tag, "_done"}, 272'(done), 272'(0));
        check({tag, "_err"}, 272'(err), 272'(0));
    endtask

    task automatic do_start(input params::type_t ty, input logic [1:0] rc, input logic lc,
                            input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        @(negedge clk);
        start = 1'b1; cfg_type = ty; cfg_rc = rc; load_c = lc;
        addr_a = a; addr_b = b; addr_c = c;
        @(negedge clk);
        start = 1'b0;
    endtask

    // AXI read slave: answers AR after ar_delay cycles, streams beats, optional bad rlast on A.
    task automatic serve(input int ar_delay, input bit jitter, input int bad_beat, input int stop_beats);
        int wait_cnt = 0;
        int beats_left = 0;
        int beat = 0;
        int cur_ar = 0;
        int accepted = 0;
        bit in_burst = 0;
        bit first_set = 0;
        logic [31:0] first_addr = '0;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (done) begin
                done_seen = 1; done_cyc = cyc_cnt; done_err = err;
                break;
            end
            if (stop_beats > 0 && accepted >= stop_beats) break;
            arready = 1'b0;
            if (arvalid && !in_burst) begin
                if (!first_set) begin first_addr = araddr; first_set = 1; end
                if (wait_cnt >= ar_delay) begin
                    if (ar_delay > 0) check($sformatf("ar%0d_stable", ar_addr_log.size()), 272'(araddr), 272'(first_addr));
                    ar_addr_log.push_back(araddr);
                    ar_len_log.push_back(int'(arlen));
                    cur_ar = ar_addr_log.size() - 1;
                    arready = 1'b1; beats_left = int'(arlen) + 1; beat = 0;
                    in_burst = 1; wait_cnt = 0; first_set = 0;
                end else begin
                    wait_cnt++;
                end
            end
            rvalid = 1'b0; rlast = 1'b0;
            if (in_burst && (!jitter || $urandom_range(0, 1) == 1)) begin
                rvalid = 1'b1;
                rdata = pat(cur_ar, beat);
                rlast = (beat == beats_left - 1) || (cur_ar == 0 && beat == bad_beat);
                if (rready) begin
                    last_beat_cyc = cyc_cnt;
                    accepted++; beat++;
                    if (beat == beats_left) in_burst = 0;
                end
            end
        end
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
        #1;
    endtask

    task automatic verify(input string tag, input int n_ar, input logic [31:0] a0, input logic [31:0] a1,
                          input logic [31:0] a2, input int l0, input int l1, input int l2,
                          input params::type_t ty, input logic [1:0] rc);
        logic [31:0] addrs[3];
        int lens[3];
        int idx = 0;
        addrs[0] = a0; addrs[1] = a1; addrs[2] = a2;
        lens[0] = l0; lens[1] = l1; lens[2] = l2;
        check({tag, "_ar_count"}, 272'(ar_addr_log.size()), 272'(n_ar));
        for (int m = 0; m < n_ar; m++) begin
            if (m < ar_addr_log.size()) begin
                check($sformatf("%s_araddr%0d", tag, m), 272'(ar_addr_log[m]), 272'(addrs[m]));
                check($sformatf("%s_arlen%0d", tag, m), 272'(ar_len_log[m]), 272'(lens[m]));
            end
            for (int b = 0; b <= lens[m]; b++) begin
                if (idx < tv_q.size())
                    check($sformatf("%s_beat_m%0d_b%0d", tag, m, b), 272'(tv_q[idx]),
                          272'({2'(m), ty, rc, 5'(b), pat(m, b)}));
                idx++;
            end
        end
        check({tag, "_beat_count"}, 272'(tv_q.size()), 272'(idx));
        check({tag, "_done_seen"}, 272'(done_seen), 272'(1));
        check({tag, "_done_lat"}, 272'(done_cyc - last_beat_cyc), 272'(2));
        check({tag, "_err"}, 272'(done_err), 272'(0));
    endtask

    initial begin
        cfg_type = params::TYPE_INT8; cfg_rc = 2'b00; load_c = 1'b0;
        addr_a = '0; addr_b = '0; addr_c = '0;
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = '0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        check("arsize", 272'(arsize), 272'(3'b101));
        check("arburst", 272'(arburst), 272'(2'b01));
        rst = 1'b0;

        // rlast early on A beat 5 of 8
        clear_logs();
        do_start(params::TYPE_INT8, 2'b00, 1'b1, 32'h3000, 32'h4000, 32'h5000);
        serve(0, 0, 5, 0);
        check("early_ar_count", 272'(ar_addr_log.size()), 272'(1));
        check("early_beats", 272'(tv_q.size()), 272'(6));
        for (int b = 0; b < 6; b++)
            if (b < tv_q.size())
                check($sformatf("early_beat%0d", b), 272'(tv_q[b]),
                      272'({2'd0, params::TYPE_INT8, 2'b00, 5'(b), pat(0, b)}));
        check("early_done_seen", 272'(done_seen), 272'(1));
        check("early_err", 272'(done_err), 272'(1));
        check("early_done_lat", 272'(done_cyc - last_beat_cyc), 272'(1));
        @(negedge clk);
        check("early_idle_busy", 272'(busy), 272'(0));
        check("early_no_ar", 272'(arvalid), 272'(0));
        check("early_err_sticky", 272'(err), 272'(1));

        // illegal shape
        do_start(params::TYPE_FP16, 2'b11, 1'b0, 32'h0, 32'h0, 32'h0);
        check("rc11_arvalid", 272'(arvalid), 272'(0));
        check("rc11_err", 272'(err), 272'(1));
        check("rc11_done", 272'(done), 272'(1));
        @(negedge clk);
        check("rc11_done_pulse", 272'(done), 272'(0));
        check("rc11_busy", 272'(busy), 272'(0));
        check("rc11_err_sticky", 272'(err), 272'(1));

        // FP32 A+B, legal start clears err
        clear_logs();
        do_start(params::TYPE_FP32, 2'b00, 1'b0, 32'h1000, 32'h2000, 32'h0);
        check("fp32_err_clear", 272'(err), 272'(0));
        check("fp32_arvalid_t1", 272'(arvalid), 272'(1));
        check("fp32_busy", 272'(busy), 272'(1));
        serve(0, 0, -1, 0);
        verify("fp32", 2, 32'h1000, 32'h2000, 32'h0, 15, 7, 0, params::TYPE_FP32, 2'b00);

        // INT4 with C
        clear_logs();
        do_start(params::TYPE_INT4, 2'b10, 1'b1, 32'h0001_0000, 32'h0002_0020, 32'h0003_0040);
        serve(0, 0, -1, 0);
        verify("int4", 3, 32'h0001_0000, 32'h0002_0020, 32'h0003_0040, 7, 15, 31, params::TYPE_INT4, 2'b10);

        // same load with delayed arready and ragged rvalid
        clear_logs();
        do_start(params::TYPE_INT4, 2'b10, 1'b1, 32'h0001_0000, 32'h0002_0020, 32'h0003_0040);
        serve(3, 1, -1, 0);
        verify("jitter", 3, 32'h0001_0000, 32'h0002_0020, 32'h0003_0040, 7, 15, 31, params::TYPE_INT4, 2'b10);

        // reset during B data, then a clean run
        clear_logs();
        do_start(params::TYPE_FP32, 2'b01, 1'b0, 32'h1000, 32'h2000, 32'h0);
        serve(0, 0, -1, 19);
        rst = 1'b1;
        @(negedge clk);
        check_reset("midrst");
        rst = 1'b0;
        clear_logs();
        do_start(params::TYPE_FP32, 2'b01, 1'b0, 32'h1000, 32'h2000, 32'h0);
        serve(0, 0, -1, 0);
        verify("after_rst", 2, 32'h1000, 32'h2000, 32'h0, 15, 7, 0, params::TYPE_FP32, 2'b01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/trans_load_ctrl.md
# trans_load_ctrl

Sequencer that loads one MMA operand set (A, B, optionally C) from memory through the TRANS layout converter. On a start command it issues one AXI4 read burst per matrix, accepts the 256-bit R beats, and presents each beat to TRANS with the matching `mat`, `data_type`, `rc`, `burst_num` and `valid`. It then signals completion once the last write has left TRANS. It sits between the AXI master port and TRANS, ahead of the systolic array start.

## Interface
- ADDR_W, 32, AXI address width
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; latches command when idle
- cfg_type  in  params::type_t  operand data type
- cfg_rc  in  params::rc_t  shape select (00 M32N8, 01 M16N16, 10 M8N32; 11 illegal)
- load_c  in  1  also load C after B
- addr_a / addr_b / addr_c  in  ADDR_W each  byte base addresses, 32-byte aligned
- araddr  out  ADDR_W; arlen  out  8; arsize  out  3 (constant 3'b101); arburst  out  2 (constant INCR 2'b01); arvalid  out  1; arready  in  1
- rdata  in  256; rlast  in  1; rvalid  in  1; rready  out  1
- trans_data  out  256; trans_burst  out  5; trans_mat  out  params::mat_t; trans_type  out  params::type_t; trans_rc  out  params::rc_t; trans_valid  out  1 (all registered; connect to TRANS `data_in`/`burst_num`/`mat`/`data_type`/`rc`/`valid`)
- busy  out  1; done  out  1 (pulse); err  out  1 (sticky until next accepted start)

## Operation
- FSM: IDLE, ADDR, DATA, DRAIN, ERROR. Register `cur_mat` (A→B→C), `beat_cnt` (5 bit), latched type/rc/load_c/addresses.
- IDLE: `start`=1 latches the command. If rc==2'b11, go to ERROR. Otherwise set cur_mat=A and go to ADDR. `start` outside IDLE is ignored.
- Beat count N per matrix:
  - A: 16 for FP32, else 8.
  - B: 16 for INT4, else 8.
  - C: always 32.
- ADDR: arvalid=1, araddr = base of cur_mat, arlen=N-1. On arready: beat_cnt=0, go to DATA. araddr/arlen stay stable while arvalid && !arready.
- DATA: rready=1. Each accepted beat (rvalid&rready) registers trans_data=rdata, trans_burst=beat_cnt, trans_mat=cur_mat, trans_type/rc=latched, trans_valid=1. beat_cnt then increments.
  - Expected last beat is beat_cnt==N-1.
  - If rlast disagrees with expected-last on any accepted beat: still forward the beat, then go to ERROR.
  - On a correct last beat: A→ADDR with B. B→ADDR with C if load_c, else DRAIN. C→DRAIN.
- DRAIN: wait one cycle (TRANS output register), then done=1 for one cycle, go to IDLE.
- ERROR: err=1, done=1 for one cycle, go to IDLE. No further AR issued. Stray R beats arriving in IDLE are not accepted (rready=0).
- busy=1 in every state except IDLE.
- trans_valid=0 on every cycle without an accepted beat; trans_data/burst hold their last value.

## Timing
- Reset values:
  - FSM=IDLE, beat_cnt=0, cur_mat=A.
  - arvalid=0, rready=0, trans_valid=0, trans_data=0, trans_burst=0.
  - trans_mat=A, trans_type/trans_rc = 0 encoding.
  - busy=0, done=0, err=0.
- `rst` mid-operation aborts immediately: no AXI completion is awaited, and the outstanding burst is the integrator's responsibility.
- start at cycle T → arvalid at T+1.
- Beat accepted at T → trans_valid at T+1 → TRANS write enables at T+2.
- Final beat at T → done at T+2 (DRAIN occupies T+1).
- AR for the next matrix issues the cycle after the previous matrix's last beat; no R acceptance in ADDR.
- rvalid with rready=0 is not consumed. Back-to-back beats sustain one beat per cycle.
- err clears on the cycle a legal start is accepted. It asserts the cycle ERROR is entered and stays asserted until then.

## Test plan
- FP32, rc=00, load_c=0, addr_a=0x1000, addr_b=0x2000: expect
  - AR (0x1000, arlen=15) then (0x2000, arlen=7);
  - 24 trans_valid pulses, burst 0..15 with mat=A then 0..7 with mat=B;
  - done 2 cycles after the last beat, err=0.
- INT4, rc=10, load_c=1: expect arlen 7/15/31, and C beats carry trans_burst 0..31 with mat=C.
- rvalid toggled randomly with arready delayed 3 cycles: beat order and burst numbering unchanged, no beat lost or duplicated.
- rlast asserted on A beat 5 (expected 7): expect
  - beats 0..5 forwarded;
  - err=1 and done=1 in the same cycle, then IDLE;
  - no AR for B.
- start with rc=11: no arvalid, err=1 and done=1 on cycle T+1; a second legal start clears err.
- rst asserted mid-B DATA phase: the next cycle has all outputs at reset values; a following start runs a clean full sequence.
